// File: rtl/lsu_mmio.sv
// Load/store unit with memory-mapped I/O for the RV32I core family.
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both high. Only one request is
// outstanding at a time. While rsp_valid_o is high, rsp_rdata_o and
// rsp_err_o do not change.
module lsu_mmio #(
   parameter int DMEM_WORDS   = 512,
   parameter int DMEM_LATENCY = 1,
   parameter int NUM_HEX      = 8,
   parameter int NUM_LCD      = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [2:0]           req_funct3_i,
   input  logic [31:0]          req_addr_i,
   input  logic [31:0]          req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_err_o,
   input  logic [31:0]          io_sw_i,
   input  logic [31:0]          io_key_i,
   output logic [31:0]          io_ledr_o,
   output logic [31:0]          io_ledg_o,
   output logic [NUM_HEX*32-1:0] io_hex_o,
   output logic [NUM_LCD*32-1:0] io_lcd_o
);
   localparam int AW = $clog2(DMEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] lcd_q [NUM_LCD];
   logic [31:0] hex_q [NUM_HEX];
   logic [31:0] ledr_q, ledg_q;
   logic [31:0] sw_meta_q, sw_sync_q, key_meta_q, key_sync_q;

   logic [11:0] a;
   logic [2:0]  idx;
   logic        is_dmem, is_lcd, is_hex, is_ledr, is_ledg, is_key, is_sw, mapped;
   logic        is_b, is_h, is_w, f3_ok, misalign, st_bad, req_err;
   logic [3:0]  be;
   logic [31:0] wrep, rd_word, shifted, load_data;
   logic        accept, commit;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^req_addr_i[31:12];

   // Address decode on the word address; byte offsets select lanes later.
   assign a       = req_addr_i[11:0];
   assign idx     = a[4:2];
   assign is_dmem = ({1'b0, a} < 13'(DMEM_WORDS * 4));
   assign is_lcd  = (a[11:5] == 7'h40) && ({29'd0, idx} < 32'(NUM_LCD));
   assign is_hex  = (a[11:5] == 7'h41) && ({29'd0, idx} < 32'(NUM_HEX));
   assign is_ledr = (a[11:2] == 10'h210);
   assign is_ledg = (a[11:2] == 10'h211);
   assign is_key  = (a[11:2] == 10'h280);
   assign is_sw   = (a[11:2] == 10'h281);
   assign mapped  = is_dmem | is_lcd | is_hex | is_ledr | is_ledg | is_key | is_sw;

   // Access size from funct3; unknown encodings are flagged.
   always_comb begin
      is_b  = 1'b0;
      is_h  = 1'b0;
      is_w  = 1'b0;
      f3_ok = 1'b1;
      case (req_funct3_i)
         3'b000, 3'b100: is_b = 1'b1;
         3'b001, 3'b101: is_h = 1'b1;
         3'b010:         is_w = 1'b1;
         default:        f3_ok = 1'b0;
      endcase
   end

   assign misalign = (is_h && a[0]) || (is_w && (a[1:0] != 2'b00));
   assign st_bad   = req_we_i && (req_funct3_i[2] || is_key || is_sw);
   assign req_err  = !f3_ok || misalign || !mapped || st_bad;

   // Byte enables and store data replicated onto every lane.
   always_comb begin
      be   = 4'b1111;
      wrep = req_wdata_i;
      if (is_b) begin
         be   = 4'b0001 << a[1:0];
         wrep = {4{req_wdata_i[7:0]}};
      end else if (is_h) begin
         be   = a[1] ? 4'b1100 : 4'b0011;
         wrep = {2{req_wdata_i[15:0]}};
      end
   end

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return res;
   endfunction

   // Read the addressed word from whichever target is selected.
   always_comb begin
      rd_word = '0;
      if (is_dmem) rd_word = dmem[a[AW+1:2]];
      if (is_ledr) rd_word = ledr_q;
      if (is_ledg) rd_word = ledg_q;
      if (is_key)  rd_word = key_sync_q;
      if (is_sw)   rd_word = sw_sync_q;
      for (int k = 0; k < NUM_LCD; k++)
         if (is_lcd && (idx == 3'(k))) rd_word = lcd_q[k];
      for (int k = 0; k < NUM_HEX; k++)
         if (is_hex && (idx == 3'(k))) rd_word = hex_q[k];
   end

   // Lane extraction followed by sign or zero extension.
   always_comb begin
      shifted = rd_word >> {a[1:0], 3'b000};
      case (req_funct3_i)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         3'b010:  load_data = rd_word;
         default: load_data = '0;
      endcase
   end

   assign req_ready_o = (state_q == S_IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign commit      = accept && req_we_i && !req_err;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   // Next-state logic; the response is captured at acceptance and held.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rdata_d = (req_err || req_we_i) ? '0 : load_data;
               err_d   = req_err;
               if (!req_err && !req_we_i && is_dmem && (DMEM_LATENCY > 1)) begin
                  state_d = S_WAIT;
                  cnt_d   = 2'(DMEM_LATENCY - 2);
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Data memory write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (commit && is_dmem)
         dmem[a[AW+1:2]] <= lane_merge(dmem[a[AW+1:2]], wrep, be);
   end

   // Output peripheral registers with per-lane writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ledr_q <= '0;
         ledg_q <= '0;
         for (int k = 0; k < NUM_LCD; k++) lcd_q[k] <= '0;
         for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= '0;
      end else if (commit) begin
         if (is_ledr) ledr_q <= lane_merge(ledr_q, wrep, be);
         if (is_ledg) ledg_q <= lane_merge(ledg_q, wrep, be);
         for (int k = 0; k < NUM_LCD; k++)
            if (is_lcd && (idx == 3'(k))) lcd_q[k] <= lane_merge(lcd_q[k], wrep, be);
         for (int k = 0; k < NUM_HEX; k++)
            if (is_hex && (idx == 3'(k))) hex_q[k] <= lane_merge(hex_q[k], wrep, be);
      end
   end

   // Two-flop synchronisers for the asynchronous switch and key inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_meta_q <= '0;
         key_sync_q <= '0;
      end else begin
         sw_meta_q  <= io_sw_i;
         sw_sync_q  <= sw_meta_q;
         key_meta_q <= io_key_i;
         key_sync_q <= key_meta_q;
      end
   end

   assign io_ledr_o = ledr_q;
   assign io_ledg_o = ledg_q;
   for (genvar k = 0; k < NUM_LCD; k++) begin : g_lcd
      assign io_lcd_o[32*k +: 32] = lcd_q[k];
   end
   for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
      assign io_hex_o[32*k +: 32] = hex_q[k];
   end
endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed scenarios followed by random
// traffic, checked against a byte-addressed reference model.
module tb_lsu_mmio;
   localparam int DMEM_WORDS = 512;
   localparam int LAT        = 3;
   localparam int NUM_HEX    = 8;
   localparam int NUM_LCD    = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                   req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [2:0]             req_f3;
   logic [31:0]            req_addr, req_wdata, rsp_rdata;
   logic [31:0]            io_sw, io_key, io_ledr, io_ledg;
   logic [NUM_HEX*32-1:0]  io_hex;
   logic [NUM_LCD*32-1:0]  io_lcd;

   lsu_mmio #(.DMEM_WORDS(DMEM_WORDS), .DMEM_LATENCY(LAT),
              .NUM_HEX(NUM_HEX), .NUM_LCD(NUM_LCD)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .io_sw_i(io_sw), .io_key_i(io_key),
      .io_ledr_o(io_ledr), .io_ledg_o(io_ledg),
      .io_hex_o(io_hex), .io_lcd_o(io_lcd)
   );

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   logic [7:0]  model_b [4096];
   logic [31:0] sw_vis, key_vis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   // 0 unmapped, 1 data memory, 2 writable I/O, 3 key/switch inputs
   function automatic int region(input int a);
      if (a < DMEM_WORDS * 4) return 1;
      if (a >= 'h800 && a < 'h800 + 4 * NUM_LCD) return 2;
      if (a >= 'h820 && a < 'h820 + 4 * NUM_HEX) return 2;
      if (a >= 'h840 && a < 'h848) return 2;
      if (a >= 'hA00 && a < 'hA08) return 3;
      return 0;
   endfunction

   function automatic logic [7:0] byte_at(input int a);
      if (a >= 'hA00 && a < 'hA04) return key_vis[8*(a - 'hA00) +: 8];
      if (a >= 'hA04 && a < 'hA08) return sw_vis[8*(a - 'hA04) +: 8];
      return model_b[a];
   endfunction

   function automatic logic [31:0] mword(input int base);
      return {model_b[base+3], model_b[base+2], model_b[base+1], model_b[base]};
   endfunction

   task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             output logic err, output logic [31:0] rd, output int lat);
      int a, sz, rg;
      logic [31:0] v;
      a   = int'(addr[11:0]);
      sz  = acc_size(f3);
      rg  = region(a);
      err = (sz == 0) || (rg == 0) || ((a % ((sz == 0) ? 1 : sz)) != 0) ||
            (we && (f3[2] || rg == 3));
      rd  = '0;
      lat = 1;
      if (!err && !we) begin
         v = '0;
         for (int i = 0; i < sz; i++) v[8*i +: 8] = byte_at(a + i);
         if (!f3[2] && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
         rd = v;
         if (rg == 1) lat = LAT;
      end
   endtask

   task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int a, sz;
      a  = int'(addr[11:0]);
      sz = acc_size(f3);
      for (int i = 0; i < sz; i++) model_b[a + i] = wd[8*i +: 8];
   endtask

   task automatic model_reset();
      for (int i = 'h800; i < 'h848; i++) model_b[i] = 8'h00;
      sw_vis  = '0;
      key_vis = '0;
   endtask

   task automatic check_io();
      chk("ledr", io_ledr, mword('h840));
      chk("ledg", io_ledg, mword('h844));
      for (int k = 0; k < NUM_HEX; k++)
         chk($sformatf("hex%0d", k), io_hex[32*k +: 32], mword('h820 + 4*k));
      for (int k = 0; k < NUM_LCD; k++)
         chk($sformatf("lcd%0d", k), io_lcd[32*k +: 32], mword('h800 + 4*k));
   endtask

   // ---------------- driver tasks ----------------
   // Drives one request, waits for its response, checks latency, data,
   // the hold behaviour while rsp_ready is low, and the I/O outputs.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int hold,
                            output logic [31:0] rd_obs, output logic err_obs);
      logic        e_err;
      logic [31:0] e_rd;
      logic [32:0] exp;
      int          e_lat, n, lat;
      ref_access(we, f3, addr, e_err, e_rd, e_lat);
      exp_q.push_back({e_err, e_rd});
      rd_obs  = '0;
      err_obs = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_f3    = f3;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk1("req_ready_wait", req_ready, 1'b1);
      if (req_ready !== 1'b1) begin
         req_valid = 1'b0;
         void'(exp_q.pop_front());
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (!e_err && we) model_store(f3, addr, wd);
      lat = 1;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(e_lat));
      exp = exp_q.pop_front();
      if (rsp_valid !== 1'b1) return;
      rd_obs  = rsp_rdata;
      err_obs = rsp_err;
      chk("rdata", rsp_rdata, exp[31:0]);
      chk1("err", rsp_err, exp[32]);
      chk1("busy_ready", req_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk1("hold_valid", rsp_valid, 1'b1);
         chk("hold_rdata", rsp_rdata, exp[31:0]);
         chk1("hold_err", rsp_err, exp[32]);
         chk1("hold_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk1("rsp_drop", rsp_valid, 1'b0);
      check_io();
   endtask

   // Drives a request and returns right after its acceptance edge.
   task automatic issue_only(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_f3    = f3;
      req_addr  = addr;
      req_wdata = wd;
      chk1("issue_ready", req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (we) model_store(f3, addr, wd);
   endtask

   // Holds reset for n cycles, checking that no response ever appears.
   task automatic pulse_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk1("rst_no_rsp", rsp_valid, 1'b0);
         chk1("rst_ready", req_ready, 1'b0);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      sw_vis  = io_sw;
      key_vis = io_key;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] oth [8];
      oth = '{32'h900, 32'hA08, 32'h848, 32'hA00, 32'hA04, 32'hFFC, 32'h81C, 32'h83C};
      req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b010;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      io_sw = '0; io_key = '0;
      for (int i = 0; i < 4096; i++) model_b[i] = 8'h00;
      sw_vis = '0; key_vis = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("reset_ready", req_ready, 1'b0);
      chk1("reset_valid", rsp_valid, 1'b0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk1("reset_err", rsp_err, 1'b0);
      check_io();
      rst = 1'b0;
      @(negedge clk);
      chk1("idle_ready", req_ready, 1'b1);
      io_key = $urandom;
      repeat (3) @(negedge clk);
      key_vis = io_key;

      // sub-word loads with extension
      do_access(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, rd, er);
      do_access(1'b0, 3'b000, 32'h013, 32'h0, 0, rd, er); chk("t1_lb", rd, 32'hFFFFFFDE);
      do_access(1'b0, 3'b100, 32'h013, 32'h0, 0, rd, er); chk("t1_lbu", rd, 32'h000000DE);
      do_access(1'b0, 3'b001, 32'h012, 32'h0, 0, rd, er); chk("t1_lh", rd, 32'hFFFFDEAD);
      do_access(1'b0, 3'b101, 32'h012, 32'h0, 0, rd, er); chk("t1_lhu", rd, 32'h0000DEAD);
      chk1("t1_err", er, 1'b0);

      // multi-cycle load held for 5 cycles
      do_access(1'b0, 3'b010, 32'h010, 32'h0, 5, rd, er); chk("t2_lw", rd, 32'hDEADBEEF);

      // LEDR byte-lane write and readback
      do_access(1'b1, 3'b010, 32'h840, 32'h12345678, 0, rd, er);
      do_access(1'b1, 3'b000, 32'h841, 32'h000000AA, 0, rd, er);
      chk("t3_ledr", io_ledr, 32'h1234AA78);
      do_access(1'b0, 3'b010, 32'h840, 32'h0, 0, rd, er); chk("t3_lw", rd, 32'h1234AA78);

      // error cases
      do_access(1'b0, 3'b010, 32'h012, 32'h0, 0, rd, er); chk1("t4_lw_mis", er, 1'b1);
      do_access(1'b1, 3'b001, 32'h011, 32'h5555, 0, rd, er); chk1("t4_sh_mis", er, 1'b1);
      do_access(1'b0, 3'b010, 32'h900, 32'h0, 0, rd, er); chk1("t4_unmapped", er, 1'b1);
      chk("t4_unmapped_rd", rd, 32'h0);
      do_access(1'b1, 3'b010, 32'hA04, 32'hFFFFFFFF, 0, rd, er); chk1("t4_sw_store", er, 1'b1);
      do_access(1'b1, 3'b100, 32'h010, 32'h11, 0, rd, er); chk1("t4_st_f3", er, 1'b1);
      do_access(1'b0, 3'b011, 32'h010, 32'h0, 0, rd, er); chk1("t4_bad_f3", er, 1'b1);
      do_access(1'b0, 3'b010, 32'h010, 32'h0, 0, rd, er); chk("t4_dmem_kept", rd, 32'hDEADBEEF);

      // switch synchroniser
      @(negedge clk);
      io_sw = 32'h0000F00F;
      do_access(1'b0, 3'b010, 32'hA04, 32'h0, 0, rd, er); chk("t5_sw_early", rd, 32'h0);
      sw_vis = io_sw;
      do_access(1'b0, 3'b010, 32'hA04, 32'h0, 0, rd, er); chk("t5_sw", rd, 32'h0000F00F);
      do_access(1'b0, 3'b100, 32'hA05, 32'h0, 0, rd, er); chk("t5_sw_lbu", rd, 32'h000000F0);
      do_access(1'b0, 3'b001, 32'hA04, 32'h0, 0, rd, er); chk("t5_sw_lh", rd, 32'hFFFFF00F);

      // random fill of a data window, then mixed random traffic
      for (int i = 0; i < 32; i++)
         do_access(1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom, 0, rd, er);
      for (int i = 0; i < 80; i++) begin
         logic [2:0]  f3;
         logic [31:0] ad;
         int          sel, fsel;
         fsel = $urandom_range(0, 9);
         f3   = (fsel > 7) ? 3'b010 : 3'(fsel);
         sel  = $urandom_range(0, 9);
         if (sel < 6)      ad = 32'h100 + 32'($urandom_range(0, 127));
         else if (sel < 9) ad = 32'h800 + 32'($urandom_range(0, 71));
         else              ad = oth[$urandom_range(0, 7)];
         do_access(1'($urandom_range(0, 1)), f3, ad, $urandom, $urandom_range(0, 2), rd, er);
      end

      // reset during a multi-cycle load, and after an accepted store
      do_access(1'b1, 3'b010, 32'h844, 32'hA5A5A5A5, 0, rd, er);
      issue_only(1'b1, 3'b010, 32'h020, 32'hCAFEF00D);
      pulse_reset(1);
      check_io();
      issue_only(1'b0, 3'b010, 32'h010, 32'h0);
      @(negedge clk);
      chk1("t6_in_wait", rsp_valid, 1'b0);
      pulse_reset(2);
      chk("t6_ledr", io_ledr, 32'h0);
      chk("t6_ledg", io_ledg, 32'h0);
      check_io();
      do_access(1'b0, 3'b010, 32'h010, 32'h0, 0, rd, er); chk("t6_dmem", rd, 32'hDEADBEEF);
      do_access(1'b0, 3'b010, 32'h020, 32'h0, 0, rd, er); chk("t6_store_kept", rd, 32'hCAFEF00D);
      do_access(1'b0, 3'b010, 32'h100, 32'h0, 1, rd, er);

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
